// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 32-lane TDM receive demultiplexer.
// State encoding, slot geometry and the slot-0 constant live here.
package tdm_demux_pkg;

   localparam int SEL_W    = 5;
   localparam int CHANNELS = 32;

   localparam logic [SEL_W-1:0] SLOT0 = '0;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PARITY
   } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-1 beats clear beats increment; wraps naturally at max.
// wrap flags the last slot of a frame so the FSM can close it out.
module tdm_slot_counter #(
   parameter int W = tdm_demux_pkg::SEL_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   input  logic         load1,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= W'(1);
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign wrap = (cnt == {W{1'b1}});

endmodule

// File: rtl/tdm_demux32.sv
// TDM serial-to-parallel receiver: one bit per din_valid cycle into lane out[slot].
// out/out_valid update 1 clk after the closing bit; din_valid low simply holds all state.
// Optional even-parity trailer bit per frame when TDM_PARITY_EN is defined.
module tdm_demux32 #(
   parameter int CHANNELS = tdm_demux_pkg::CHANNELS,
   parameter int SEL_W    = tdm_demux_pkg::SEL_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   input  logic                din_valid,
   input  logic                frame_start,
   output logic [CHANNELS-1:0] out,
   output logic                out_valid,
   output logic [SEL_W-1:0]    slot,
   output logic                locked,
   output logic                frame_err,
   output logic                par_err
);

   import tdm_demux_pkg::*;

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] shadow, shadow_nxt;
   logic                cnt_inc, cnt_clr, cnt_load1, slot_wrap;
   logic                restart, store, frame_done, ferr_nxt;
`ifdef TDM_PARITY_EN
   logic                par_acc, perr_nxt;
`endif

   tdm_slot_counter #(.W(SEL_W)) u_slot_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .cnt   (slot),
      .wrap  (slot_wrap)
   );

   always_comb begin
      state_nxt  = state;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      restart    = 1'b0;
      store      = 1'b0;
      frame_done = 1'b0;
      ferr_nxt   = 1'b0;
`ifdef TDM_PARITY_EN
      perr_nxt   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (din_valid && frame_start) begin
               restart   = 1'b1;
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (din_valid) begin
               // A misplaced frame_start resynchronises: its bit becomes the new slot 0.
               if (frame_start && (slot != SEL_W'(SLOT0))) begin
                  restart  = 1'b1;
                  ferr_nxt = 1'b1;
               end else begin
                  store   = 1'b1;
                  cnt_inc = 1'b1;
                  if (slot_wrap) begin
`ifdef TDM_PARITY_EN
                     state_nxt = PARITY;
`else
                     frame_done = 1'b1;
`endif
                  end
               end
            end
         end
`ifdef TDM_PARITY_EN
         PARITY: begin
            if (din_valid) begin
               state_nxt = COLLECT;
               if (frame_start) begin
                  restart  = 1'b1;
                  ferr_nxt = 1'b1;
               end else begin
                  cnt_clr = 1'b1;
                  if (par_acc ^ din) begin
                     perr_nxt = 1'b1;
                  end else begin
                     frame_done = 1'b1;
                  end
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   assign cnt_load1 = restart;

   always_comb begin
      shadow_nxt = shadow;
      if (restart) begin
         shadow_nxt[0] = din;
      end else if (store) begin
         shadow_nxt[slot] = din;
      end
   end

   // out is loaded from shadow_nxt so the closing data bit lands in the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shadow    <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         out_valid <= frame_done;
         frame_err <= ferr_nxt;
         if (frame_done) begin
            out <= shadow_nxt;
         end
      end
   end

`ifdef TDM_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_acc <= 1'b0;
         par_err <= 1'b0;
      end else begin
         par_err <= perr_nxt;
         if (restart) begin
            par_acc <= din;
         end else if (store) begin
            par_acc <= par_acc ^ din;
         end
      end
   end
`else
   assign par_err = 1'b0;
`endif

   assign locked = (state != IDLE);

endmodule

// File: tb/tb_tdm_demux32.sv
// Directed bench for tdm_demux32: table of whole frames plus hand-written corner sequences.
// Parity trailer bits are sent only when TDM_PARITY_EN is defined.
module tb_tdm_demux32;

   logic        clk = 1'b0;
   logic        rst, din, din_valid, frame_start;
   logic [31:0] out;
   logic        out_valid, locked, frame_err, par_err;
   logic [4:0]  slot;

   int total = 0;
   int bad = 0;
   int ov_cnt, fe_cnt, pe_cnt;
   logic [31:0] model_out;

   typedef struct {
      logic [31:0] data;
      logic        fs;
      int          gap;
      logic [31:0] exp_out;
      int          exp_ov;
      int          exp_fe;
   } vec_t;

   vec_t tbl [4];

   tdm_demux32 dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .out         (out),
      .out_valid   (out_valid),
      .slot        (slot),
      .locked      (locked),
      .frame_err   (frame_err),
      .par_err     (par_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, then sample 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic d, input logic fs);
      din_valid   = v;
      din         = d;
      frame_start = fs;
      @(posedge clk);
      #1;
      if (out_valid) ov_cnt++;
      if (frame_err) fe_cnt++;
      if (par_err)   pe_cnt++;
   endtask

   task automatic send_range(input logic [31:0] d, input int lo, input int hi,
                             input logic fs_first, input int gap, input logic with_par);
      for (int i = lo; i <= hi; i++) begin
         cyc(1'b1, d[i], fs_first && (i == lo));
         if (i == 15) chk("mid_frame_out_hold", out, model_out);
         for (int g = 0; g < gap; g++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk("gap_slot_frozen", 32'(slot), 32'((i + 1) % 32));
         end
      end
`ifdef TDM_PARITY_EN
      if (with_par) cyc(1'b1, ^d, 1'b0);
`else
      if (with_par) begin end
`endif
   endtask

   initial begin
      tbl[0] = '{32'hA5A5_0F0F, 1'b1, 0, 32'hA5A5_0F0F, 1, 0};
      tbl[1] = '{32'hFFFF_0000, 1'b0, 0, 32'hFFFF_0000, 1, 0};
      tbl[2] = '{32'h1234_5678, 1'b0, 3, 32'h1234_5678, 1, 0};
      tbl[3] = '{32'h8000_0001, 1'b1, 0, 32'h8000_0001, 1, 0};

      rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;
      ov_cnt = 0; fe_cnt = 0; pe_cnt = 0; model_out = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", out, 32'h0);
      chk("rst_slot", 32'(slot), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      chk("rst_par_err", 32'(par_err), 32'h0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // Reset in the middle of a frame
      send_range(32'h0000_03FF, 0, 9, 1'b1, 0, 1'b0);
      chk("midframe_slot", 32'(slot), 32'd10);
      chk("midframe_locked", 32'(locked), 32'h1);
      rst = 1'b1;
      #1;
      chk("async_rst_out", out, 32'h0);
      chk("async_rst_slot", 32'(slot), 32'h0);
      chk("async_rst_locked", 32'(locked), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("async_rst_no_ov", 32'(ov_cnt + int'(out_valid)), 32'h0);

      for (int k = 0; k < 4; k++) begin
         ov_cnt = 0; fe_cnt = 0;
         send_range(tbl[k].data, 0, 31, tbl[k].fs, tbl[k].gap, 1'b1);
         if (tbl[k].gap == 0) chk("ov_timing", 32'(out_valid), 32'h1);
         model_out = tbl[k].exp_out;
         chk("tbl_out", out, tbl[k].exp_out);
         chk("tbl_ov_count", 32'(ov_cnt), 32'(tbl[k].exp_ov));
         chk("tbl_fe_count", 32'(fe_cnt), 32'(tbl[k].exp_fe));
         chk("tbl_slot_wrap", 32'(slot), 32'h0);
         chk("tbl_locked", 32'(locked), 32'h1);
      end

      // frame_start at slot 17 resynchronises
      ov_cnt = 0; fe_cnt = 0;
      send_range(32'h5555_AAAA, 0, 16, 1'b0, 0, 1'b0);
      chk("resync_pre_slot", 32'(slot), 32'd17);
      cyc(1'b1, 1'b1, 1'b1);
      chk("resync_frame_err", 32'(frame_err), 32'h1);
      chk("resync_slot", 32'(slot), 32'h1);
      chk("resync_out_held", out, model_out);
      cyc(1'b0, 1'b0, 1'b0);
      chk("resync_err_pulse_end", 32'(frame_err), 32'h0);
      send_range(32'hDEAD_BEEF, 1, 31, 1'b0, 0, 1'b1);
      model_out = 32'hDEAD_BEEF;
      chk("resync_next_out", out, 32'hDEAD_BEEF);
      chk("resync_ov_count", 32'(ov_cnt), 32'h1);
      chk("resync_fe_count", 32'(fe_cnt), 32'h1);

      // IDLE ignores valid bits without frame_start
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ov_cnt = 0; fe_cnt = 0; pe_cnt = 0; model_out = '0;
      for (int i = 0; i < 40; i++) cyc(1'b1, i[0] ^ i[2], 1'b0);
      chk("idle_locked", 32'(locked), 32'h0);
      chk("idle_out", out, 32'h0);
      chk("idle_slot", 32'(slot), 32'h0);
      chk("idle_ov_count", 32'(ov_cnt), 32'h0);
      chk("idle_fe_count", 32'(fe_cnt), 32'h0);
      chk("idle_pe_count", 32'(pe_cnt), 32'h0);

`ifdef TDM_PARITY_EN
      ov_cnt = 0; pe_cnt = 0;
      send_range(32'h0000_0003, 0, 31, 1'b1, 0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      model_out = 32'h0000_0003;
      chk("par_ok_out", out, 32'h0000_0003);
      chk("par_ok_ov", 32'(ov_cnt), 32'h1);
      chk("par_ok_pe", 32'(pe_cnt), 32'h0);
      send_range(32'h0000_0007, 0, 31, 1'b0, 0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("par_bad_pulse", 32'(par_err), 32'h1);
      chk("par_bad_out_held", out, 32'h0000_0003);
      chk("par_bad_ov", 32'(ov_cnt), 32'h1);
      chk("par_bad_slot", 32'(slot), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
